// File: rtl/mux_scan_collector_if.sv
`default_nettype none
// ============================================================================
// Module  : mux_scan_collector_if
// Brief   : Mux select/sample path and frame handshake of the scan collector.
// Revision: 1.0
// ============================================================================
interface mux_scan_collector_if #(
    parameter int NUM_INPUTS = 31,
    parameter int WIDTH      = 2,
    parameter int SEL_W      = 5
);
    logic                        start;
    logic [WIDTH-1:0]            mux_out;
    logic [SEL_W-1:0]            sel;
    logic                        busy;
    logic [NUM_INPUTS*WIDTH-1:0] frame;
    logic                        frame_valid;
    logic                        frame_ready;
    logic [7:0]                  scan_count;

    modport master (
        input  start, mux_out, frame_ready,
        output sel, busy, frame, frame_valid, scan_count
    );

    modport slave (
        output start, mux_out, frame_ready,
        input  sel, busy, frame, frame_valid, scan_count
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_collector.sv
`default_nettype none
// ============================================================================
// Module  : mux_scan_collector
// Brief   : Steps the mux select through every input, packs one sample per
//           cycle into a frame and offers it on a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module mux_scan_collector #(
    parameter int NUM_INPUTS = 31,
    parameter int WIDTH      = 2,
    parameter int SEL_W      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    mux_scan_collector_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(NUM_INPUTS - 1);
    localparam logic [SEL_W-1:0] c_sel_one  = SEL_W'(1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [SEL_W-1:0]            r_sel;
    logic [SEL_W-1:0]            w_sel_next;
    logic [NUM_INPUTS*WIDTH-1:0] r_frame;
    logic [NUM_INPUTS*WIDTH-1:0] w_frame_next;
    logic                        r_frame_valid;
    logic                        w_frame_valid_next;
    logic [7:0]                  r_scan_count;
    logic [7:0]                  w_scan_count_next;
    logic                        w_handshake;

    assign w_handshake = r_frame_valid & bus.frame_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_scan_count  <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_frame       <= w_frame_next;
            r_frame_valid <= w_frame_valid_next;
            r_scan_count  <= w_scan_count_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_sel_next         = r_sel;
        w_frame_next       = r_frame;
        w_frame_valid_next = r_frame_valid;
        w_scan_count_next  = r_scan_count;

        case (r_state)
            S_IDLE: begin
                w_sel_next = '0;
                if (bus.start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (r_sel == SEL_W'(k)) begin
                        w_frame_next[k*WIDTH +: WIDTH] = bus.mux_out;
                    end
                end
                // Compare before incrementing so sel never reaches the unused code.
                if (r_sel == c_last_sel) begin
                    w_state_next       = S_DONE;
                    w_frame_valid_next = 1'b1;
                end else begin
                    w_sel_next = r_sel + c_sel_one;
                end
            end
            S_DONE: begin
                if (w_handshake) begin
                    w_state_next       = S_IDLE;
                    w_frame_valid_next = 1'b0;
                    w_sel_next         = '0;
                    w_scan_count_next  = r_scan_count + 8'd1;
                end
            end
            default: begin
                w_state_next       = S_IDLE;
                w_sel_next         = '0;
                w_frame_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.sel         = r_sel;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_frame_valid;
    assign bus.scan_count  = r_scan_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_scan_collector
// Brief   : Directed self-checking bench for mux_scan_collector.
// Revision: 1.0
// ============================================================================
module tb_mux_scan_collector;

    localparam int NUM_INPUTS = 31;
    localparam int WIDTH      = 2;
    localparam int SEL_W      = 5;

    localparam logic [61:0] c_frame_mod4 = 62'h24E4E4E4E4E4E4E4;
    localparam logic [61:0] c_frame_rev4 = 62'h1B1B1B1B1B1B1B1B;
    localparam logic [61:0] c_frame_ones = {62{1'b1}};

    logic clk;
    logic reset;
    logic [1:0] inp [NUM_INPUTS];
    int   total;
    int   bad;
    int   cyc;
    int   exp_cnt;

    mux_scan_collector_if #(.NUM_INPUTS(NUM_INPUTS), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    mux_scan_collector #(.NUM_INPUTS(NUM_INPUTS), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational 31:1 mux model; the unused code 31 reads as zero.
    always_comb begin
        bus.mux_out = 2'b00;
        if (bus.sel < 5'd31) bus.mux_out = inp[bus.sel];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (bus.frame_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (bus.frame_valid !== 1'b1) chk("valid_timeout", {63'd0, bus.frame_valid}, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sel"},   {59'd0, bus.sel}, 64'd0);
        chk({tag, "_busy"},  {63'd0, bus.busy}, 64'd0);
        chk({tag, "_valid"}, {63'd0, bus.frame_valid}, 64'd0);
        chk({tag, "_frame"}, {2'b00, bus.frame}, 64'd0);
        chk({tag, "_count"}, {56'd0, bus.scan_count}, 64'd0);
    endtask

    initial begin
        int t0;
        total       = 0;
        bad         = 0;
        exp_cnt     = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.frame_ready = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) inp[k] = 2'(k % 4);

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_sel", {59'd0, bus.sel}, 64'd0);

        // Single scan with k mod 4 pattern and immediate acceptance.
        bus.frame_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("scan_busy", {63'd0, bus.busy}, 64'd1);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            chk("scan_sel", {59'd0, bus.sel}, 64'(k));
            chk("scan_novalid", {63'd0, bus.frame_valid}, 64'd0);
            @(negedge clk);
        end
        chk("s1_valid", {63'd0, bus.frame_valid}, 64'd1);
        chk("s1_sel_last", {59'd0, bus.sel}, 64'd30);
        chk("s1_frame", {2'b00, bus.frame}, {2'b00, c_frame_mod4});
        @(negedge clk);
        exp_cnt++;
        chk("s1_valid_drop", {63'd0, bus.frame_valid}, 64'd0);
        chk("s1_busy_drop", {63'd0, bus.busy}, 64'd0);
        chk("s1_sel_zero", {59'd0, bus.sel}, 64'd0);
        chk("s1_count", {56'd0, bus.scan_count}, 64'(exp_cnt));

        // Backpressure plus a start pulse at sel=12 that must be ignored.
        for (int k = 0; k < NUM_INPUTS; k++) inp[k] = 2'(3 - (k % 4));
        bus.frame_ready = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.sel != 5'd12 && bus.busy === 1'b1) @(negedge clk);
        chk("bp_at12", {59'd0, bus.sel}, 64'd12);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(40);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_frame", {2'b00, bus.frame}, {2'b00, c_frame_rev4});
            chk("bp_sel", {59'd0, bus.sel}, 64'd30);
            chk("bp_valid", {63'd0, bus.frame_valid}, 64'd1);
        end
        chk("bp_count_hold", {56'd0, bus.scan_count}, 64'(exp_cnt));
        bus.frame_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("bp_valid_drop", {63'd0, bus.frame_valid}, 64'd0);
        chk("bp_busy_drop", {63'd0, bus.busy}, 64'd0);
        chk("bp_count", {56'd0, bus.scan_count}, 64'(exp_cnt));
        repeat (2) @(negedge clk);
        chk("no_restart", {63'd0, bus.busy}, 64'd0);
        chk("no_extra_count", {56'd0, bus.scan_count}, 64'(exp_cnt));

        // Asynchronous reset in the middle of a scan.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.sel != 5'd15 && bus.busy === 1'b1) @(negedge clk);
        chk("rst_at15", {59'd0, bus.sel}, 64'd15);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;

        for (int k = 0; k < NUM_INPUTS; k++) inp[k] = 2'b11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(40);
        chk("ones_frame", {2'b00, bus.frame}, {2'b00, c_frame_ones});
        @(negedge clk);
        exp_cnt++;
        chk("ones_count", {56'd0, bus.scan_count}, 64'(exp_cnt));

        // 256 back-to-back scans from a fresh reset: counter wraps to zero.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) inp[k] = 2'(k % 4);
        bus.start = 1'b1;
        bus.frame_ready = 1'b1;
        t0 = 0;
        for (int s = 0; s < 256; s++) begin
            wait_valid(40);
            if (s > 0) chk("spacing", 64'(cyc - t0), 64'd33);
            t0 = cyc;
            @(negedge clk);
            if (s == 254) chk("count_255", {56'd0, bus.scan_count}, 64'd255);
        end
        bus.start = 1'b0;
        chk("count_wrap", {56'd0, bus.scan_count}, 64'd0);
        chk("wrap_frame", {2'b00, bus.frame}, {2'b00, c_frame_mod4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
